// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and divisor helper
package uart_pkg;

  typedef enum logic [2:0] {
    RECOVER,
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_MID = 8;

  // Clocks per oversample tick, rounded to nearest
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
  endfunction

  // Two-of-three vote over the sample window
  function automatic logic majority3(input logic [2:0] w);
    return (w[0] & w[1]) | (w[0] & w[2]) | (w[1] & w[2]);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick divider with synchronous clear
module uart_baud_tick #(
  parameter int DIV = 54
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_div_check
    $error("uart_baud_tick: DIV must be at least 2");
  end

  logic [CW-1:0] cnt_q;
  logic          at_end;

  assign at_end = (cnt_q == CW'(DIV - 1));
  assign tick   = at_end;

  // Count 0..DIV-1; clear restarts the phase so ticks align to a start edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear || at_end) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 receiver, 16x oversampling with 3-sample majority vote
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] uart_data,
  output logic       uart_data_valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int DIV = baud_div(CLK_FREQ_HZ, BAUD_RATE);

  if (DIV < 2) begin : g_div_check
    $error("uart_rx: clock too slow for requested baud rate");
  end

  logic           rx_meta_q;
  logic           rx_s_q;
  logic [1:0]     prime_q;
  uart_rx_state_t state_q;
  logic [3:0]     scnt_q;
  logic [2:0]     bitcnt_q;
  logic [2:0]     win_q;
  logic [7:0]     shreg_q;
  logic [7:0]     data_q;
  logic           valid_q;
  logic           ferr_q;

  logic           tick;
  logic           clear;
  logic           in_window;
  logic           mid_tick;
  logic           wrap;
  logic [2:0]     win_d;
  logic           bit_d;

  // Two-flop synchronizer; prime_q marks when rx_s_q holds a real line sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      prime_q   <= 2'b00;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      prime_q   <= {prime_q[0], 1'b1};
    end
  end

  assign clear = (state_q == IDLE) && !rx_s_q;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .tick    (tick)
  );

  assign in_window = (scnt_q >= 4'(SAMPLE_MID - 1)) && (scnt_q <= 4'(SAMPLE_MID + 1));
  assign mid_tick  = tick && (scnt_q == 4'(SAMPLE_MID + 1));
  assign wrap      = tick && (scnt_q == 4'd15);
  assign win_d     = {win_q[1:0], rx_s_q};
  assign bit_d     = majority3(win_d);

  // Frame FSM with sample counter, shift register and registered strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RECOVER;
      scnt_q   <= 4'd0;
      bitcnt_q <= 3'd0;
      win_q    <= 3'd0;
      shreg_q  <= 8'h00;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      if (tick && in_window) begin
        win_q <= win_d;
      end
      if (tick) begin
        scnt_q <= scnt_q + 4'd1;
      end
      case (state_q)
        RECOVER: begin
          // Stale reset values in the synchronizer must not count as idle line
          if (prime_q[1] && rx_s_q) begin
            state_q <= IDLE;
          end
        end
        IDLE: begin
          if (!rx_s_q) begin
            state_q <= START;
            scnt_q  <= 4'd0;
          end
        end
        START: begin
          if (mid_tick && bit_d) begin
            state_q <= IDLE;
          end else if (wrap) begin
            state_q  <= DATA;
            bitcnt_q <= 3'd0;
          end
        end
        DATA: begin
          if (mid_tick) begin
            shreg_q <= {bit_d, shreg_q[7:1]};
          end
          if (wrap) begin
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              state_q <= STOP;
            end
          end
        end
        STOP: begin
          // Leave at mid stop bit so the next start edge is not missed
          if (mid_tick) begin
            if (bit_d) begin
              data_q  <= shreg_q;
              valid_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= RECOVER;
            end
          end
        end
        default: state_q <= RECOVER;
      endcase
    end
  end

  assign uart_data       = data_q;
  assign uart_data_valid = valid_q;
  assign framing_error   = ferr_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx
module tb_uart_rx;

  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD   = 625_000;
  localparam int DIV    = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int BIT    = 16 * DIV;
  localparam int LAT    = 1542;
  localparam int FAST   = 155;
  localparam int SLOW   = 165;
  localparam int FERR   = 256;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] uart_data;
  logic       uart_data_valid;
  logic       framing_error;
  logic       busy;

  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         exp_q[$];
  int         e;
  logic [7:0] last_good = 8'h00;
  int         t_start = 0;
  int         t_valid = 0;
  bit         mon_en = 1'b0;
  int         low_run = 0;
  int         max_low = 0;
  logic [7:0] pal [5] = '{8'h02, 8'h07, 8'hF0, 8'h80, 8'h40};

  uart_rx #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD_RATE   (BAUD)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .rx              (rx),
    .uart_data       (uart_data),
    .uart_data_valid (uart_data_valid),
    .framing_error   (framing_error),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame at 'per' clocks per bit; glitch flips the middle tick of each data bit
  task automatic send_frame(input logic [7:0] b, input int per, input logic stopv, input bit glitch);
    logic [9:0] bits;
    bits = {stopv, b, 1'b0};
    t_start = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      if (glitch && i >= 1 && i <= 8) begin
        clks(8 * DIV + DIV / 2);
        rx = ~bits[i];
        clks(DIV);
        rx = bits[i];
        clks(per - 9 * DIV - DIV / 2);
      end else begin
        clks(per);
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      clks(1);
      n++;
    end
    chk("drain_expected_strobes", exp_q.size(), 0);
  endtask

  // Scoreboard: every strobe must match the head of the expected-event queue
  always @(negedge clk) begin
    if (mon_en) begin
      if (!busy) begin
        low_run++;
        if (low_run > max_low) max_low = low_run;
      end else begin
        low_run = 0;
      end
    end
    if (!reset_n) begin
      last_good = 8'h00;
      chk("reset_data", uart_data, 0);
      chk("reset_valid", uart_data_valid, 0);
      chk("reset_ferr", framing_error, 0);
      chk("reset_busy", busy, 1);
    end else begin
      chk("valid_ferr_exclusive", uart_data_valid && framing_error, 0);
      if (uart_data_valid || framing_error) begin
        chk("strobe_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (e == FERR) begin
            chk("ferr_strobe", framing_error, 1);
            chk("ferr_data_held", uart_data, last_good);
          end else begin
            chk("valid_strobe", uart_data_valid, 1);
            chk("rx_byte", uart_data, e);
            last_good = 8'(e);
            t_valid = cyc;
          end
        end
      end else begin
        chk("data_hold", uart_data, last_good);
      end
    end
  end

  initial begin
    int lat;
    int per;
    logic [7:0] b;

    reset_n = 1'b0;
    rx = 1'b1;
    clks(4);
    reset_n = 1'b1;
    clks(5);
    chk("idle_after_reset", busy, 0);

    exp_q.push_back(8'h01);
    send_frame(8'h01, BIT, 1'b1, 1'b0);
    drain(4 * BIT);
    lat = t_valid - t_start;
    n_checks++;
    if (lat >= LAT - 1 && lat <= LAT + 1) n_pass++;
    else $display("FAIL latency: got %0d expected %0d +-1", lat, LAT);
    chk("single_idle", busy, 0);

    max_low = 0;
    low_run = 0;
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(pal[i]);
      send_frame(pal[i], BIT, 1'b1, 1'b0);
    end
    mon_en = 1'b0;
    drain(4 * BIT);
    n_checks++;
    if (max_low > 0 && max_low <= 8 * DIV) n_pass++;
    else $display("FAIL b2b_busy_gap: got %0d expected 1..%0d", max_low, 8 * DIV);

    rx = 1'b0;
    clks(3 * DIV);
    chk("glitch_start_busy", busy, 1);
    rx = 1'b1;
    clks(12 * DIV);
    chk("glitch_back_idle", busy, 0);

    exp_q.push_back(FERR);
    send_frame(8'h55, BIT, 1'b0, 1'b0);
    clks(2 * BIT);
    chk("recover_hold", busy, 1);
    rx = 1'b1;
    clks(10);
    chk("recover_exit", busy, 0);
    exp_q.push_back(8'hAA);
    send_frame(8'hAA, BIT, 1'b1, 1'b0);
    drain(4 * BIT);

    exp_q.push_back(8'hA5);
    send_frame(8'hA5, BIT, 1'b1, 1'b1);
    drain(4 * BIT);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, FAST, 1'b1, 1'b0);
    drain(4 * BIT);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, SLOW, 1'b1, 1'b0);
    drain(4 * BIT);

    fork
      send_frame(8'h3C, BIT, 1'b1, 1'b0);
      begin
        clks(4 * BIT + BIT / 2);
        reset_n = 1'b0;
        #1;
        chk("async_reset_data", uart_data, 0);
        chk("async_reset_valid", uart_data_valid, 0);
        chk("async_reset_ferr", framing_error, 0);
        chk("async_reset_busy", busy, 1);
        clks(3 * BIT);
        reset_n = 1'b1;
        clks(BIT / 2);
        chk("release_low_recover", busy, 1);
      end
    join
    chk("reset_frame_idle", busy, 0);
    exp_q.push_back(8'h01);
    send_frame(8'h01, BIT, 1'b1, 1'b0);
    drain(4 * BIT);

    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 2))
        0: per = FAST;
        1: per = BIT;
        default: per = SLOW;
      endcase
      exp_q.push_back(int'(b));
      send_frame(b, per, 1'b1, 1'b0);
      clks($urandom_range(0, 40));
    end
    drain(4 * BIT);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver feeding the command parser: samples the asynchronous `rx` line, recovers 8N1 frames at a fixed baud rate with 16x oversampling and 3-sample majority vote, and presents each received byte as `uart_data` with a one-cycle `uart_data_valid` strobe. It sits directly between the board UART pin and the command parser, and flags framing errors instead of forwarding corrupt bytes.

## Interface
- `CLK_FREQ_HZ`, 100_000_000: system clock frequency.
- `BAUD_RATE`, 115200: line rate.
- `OVERSAMPLE`, 16: ticks per bit; fixed, not to be overridden.
- `clk` in 1: system clock, single clock domain.
- `reset_n` in 1: reset; one clock, asynchronous assert, active-low.
- `rx` in 1: asynchronous serial input; idles high.
- `uart_data` out 8: last good byte received, LSB first on the line.
- `uart_data_valid` out 1: one-cycle strobe when `uart_data` updates.
- `framing_error` out 1: one-cycle strobe when the stop bit samples low.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- Divisor `DIV = (CLK_FREQ_HZ + BAUD_RATE*OVERSAMPLE/2) / (BAUD_RATE*OVERSAMPLE)`, rounded. Defaults give 54. `DIV < 2` is an elaboration error.
- `rx` passes through a 2-FF synchronizer. Both flops reset to 1. All decisions use the synchronized value `rx_s`.
- The tick generator counts `0..DIV-1` and emits `tick` on `DIV-1`. It clears when START is entered.
- Sample counter `scnt` is 4 bits. It increments on `tick` and wraps 15->0. At `scnt` 7, 8 and 9 it captures `rx_s` into a 3-bit window. Bit value is the majority of the window.
- States:
  - RECOVER: reset state. Go to IDLE when `rx_s`=1.
  - IDLE: when `rx_s`=0, go to START, clearing `scnt` and the divider.
  - START: when the tick at `scnt`=9 arrives:
    - majority 1 (glitch): go to IDLE.
    - otherwise continue. On the wrap to 0, go to DATA with `bitcnt`=0.
  - DATA: on the tick at `scnt`=9, shift the majority bit into `shreg` MSB (right shift, LSB-first line order). On the wrap, `bitcnt`++. After `bitcnt` reaches 7 and wraps, go to STOP.
  - STOP: on the tick at `scnt`=9:
    - majority 1: `uart_data`<=`shreg`, pulse `uart_data_valid`, go to IDLE.
    - majority 0: pulse `framing_error`, leave `uart_data` unchanged, go to RECOVER.
- STOP exits at mid-bit, so a following start edge is caught even with ±3% clock mismatch.
- `uart_data_valid` and `framing_error` are never high together.

## Timing
- Reset values:
  - `uart_data`=0x00, `uart_data_valid`=0, `framing_error`=0, `busy`=1 (RECOVER).
  - Synchronizer=1'b1, `shreg`=0, counters=0.
- Assertion of `reset_n` takes effect immediately. A frame in progress is discarded without a strobe.
- Reset release while `rx` is low (mid-frame) stays in RECOVER. No byte is produced until the line goes high and a fresh start bit arrives.
- Latency from the `rx` falling edge to `uart_data_valid` is `2 + (16 + 8*16 + 10)*DIV` = `2 + 154*DIV` clocks, ±1. At the default DIV=54 this is 8318 clocks.
- `uart_data` is registered and updates in the same cycle as the strobe. It is held stable until the next valid byte.
- There is no back-pressure. The consumer must accept a strobe in any cycle.
- Minimum spacing between strobes is one frame (160 ticks nominal).

## Structure
- `uart_pkg`:
  - state enum `uart_rx_state_t` (RECOVER, IDLE, START, DATA, STOP).
  - `OVERSAMPLE` and `SAMPLE_MID`=8 constants.
  - function `baud_div(clk_hz, baud)`.
- The package is shared with a future `uart_tx`.
- Sub-module `uart_baud_tick`: parameter DIV; inputs `clk`, `reset_n`, `clear`; output `tick`.

## Test plan
- Default parameters, send 0x01 at 115200 -> exactly one `uart_data_valid` pulse with `uart_data`=0x01, about 8318 clocks after the start edge; `framing_error` stays 0.
- Back-to-back 0x02,0x07,0xF0,0x80,0x40 with no idle gap (palette command) -> five strobes in order, correct data, `busy` low only briefly between frames.
- `rx` low for 3 ticks (162 clocks), then high -> no strobe; START->IDLE; `busy` returns to 0.
- 0x55 with stop bit driven 0 -> one `framing_error` pulse, no valid, `uart_data` unchanged, state RECOVER until `rx` high; next frame 0xAA is received correctly.
- 0xA5 with one tick inverted at `scnt`=8 in every data bit, plus transmitter baud at +3% and at -3% -> 0xA5 received in all three runs.
- `reset_n` pulsed low during data bit 3 of 0x3C and released while `rx` is low -> all outputs return to reset values immediately; no strobe for that frame; next full frame 0x01 is received.
